// File: rtl/bnn_img_pkg.sv
// Shared definitions for the 28x28 binary image buffer and its readout path.
package bnn_img_pkg;

  localparam int unsigned IMG_W      = 28;
  localparam int unsigned IMG_H      = 28;
  localparam int unsigned IMG_PIXELS = IMG_W * IMG_H;
  localparam int unsigned PIX_ADDR_W = 10;

  typedef logic image_t [0:IMG_PIXELS-1];

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSend,
    StDone
  } readout_state_e;

endpackage

// File: rtl/image_byte_packer.sv
// Combinational packer: gathers PIX_PER_BYTE pixels starting at base_i into one byte,
// pixel base_i+k in bit k, unused upper bits zero.
module image_byte_packer #(
  parameter int unsigned IMG_PIXELS   = bnn_img_pkg::IMG_PIXELS,
  parameter int unsigned PIX_PER_BYTE = 8,
  parameter int unsigned ADDR_W       = bnn_img_pkg::PIX_ADDR_W
) (
  input  logic              image_flat_i [0:IMG_PIXELS-1],
  input  logic [ADDR_W-1:0] base_i,
  output logic [7:0]        byte_o
);

  logic [ADDR_W-1:0] idx;

  always_comb begin
    byte_o = '0;
    idx    = '0;
    for (int unsigned k = 0; k < PIX_PER_BYTE; k++) begin
      idx = base_i + ADDR_W'(k);
      // Out-of-range bases only occur on the look-ahead past the last byte.
      if (32'(idx) < IMG_PIXELS) begin
        byte_o[3'(k)] = image_flat_i[idx];
      end
    end
  end

endmodule

// File: rtl/image_readout.sv
// Streams the flattened binary image out as packed bytes on a valid/ready interface,
// pixel 0 first, with abort and a one-cycle done pulse.
module image_readout #(
  parameter int unsigned IMG_PIXELS   = bnn_img_pkg::IMG_PIXELS,
  parameter int unsigned PIX_PER_BYTE = 8,
  parameter int unsigned ADDR_W       = bnn_img_pkg::PIX_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              image_ready_i,
  input  logic              image_flat_i [0:IMG_PIXELS-1],
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic [ADDR_W-1:0] read_addr_o,
  output logic              busy_o,
  output logic              done_o
);

  import bnn_img_pkg::*;

  localparam logic [ADDR_W-1:0] Step     = ADDR_W'(PIX_PER_BYTE);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(IMG_PIXELS - PIX_PER_BYTE);

  readout_state_e    state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;

  logic [ADDR_W-1:0] pack_base;
  logic [7:0]        pack_byte;
  logic              xfer;

  assign xfer = valid_q & tx_ready_i;

  // In SEND the packer looks one byte ahead so the next byte lands on the transfer edge.
  assign pack_base = (state_q == StSend) ? addr_q + Step : addr_q;

  image_byte_packer #(
    .IMG_PIXELS   (IMG_PIXELS),
    .PIX_PER_BYTE (PIX_PER_BYTE),
    .ADDR_W       (ADDR_W)
  ) u_packer (
    .image_flat_i (image_flat_i),
    .base_i       (pack_base),
    .byte_o       (pack_byte)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;

    unique case (state_q)
      StIdle: begin
        if (start_i && image_ready_i && !abort_i) begin
          addr_d  = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        data_d  = pack_byte;
        valid_d = 1'b1;
        state_d = StSend;
      end
      StSend: begin
        if (xfer) begin
          if (addr_q == LastAddr) begin
            valid_d = 1'b0;
            addr_d  = '0;
            state_d = StDone;
          end else begin
            addr_d = addr_q + Step;
            data_d = pack_byte;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides any coincident transfer or completion.
    if (abort_i && (state_q != StIdle)) begin
      state_d = StIdle;
      valid_d = 1'b0;
      addr_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign tx_data_o   = data_q;
  assign tx_valid_o  = valid_q;
  assign read_addr_o = addr_q;
  assign busy_o      = (state_q == StLoad) || (state_q == StSend);
  assign done_o      = (state_q == StDone);

endmodule
